// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
//   Shared definitions for the EX-stage execute unit:
//     - aluOp_e    : operation encoding on the 3-bit `op` bus
//     - aluState_e : execute-unit FSM states
//     - ALU_WIDTH / ALU_SHAMT_W : default datapath and shift-amount widths
//     - isShift()  : true for the four shift/rotate encodings
// -----------------------------------------------------------------------------
package alu_pkg;

   localparam int unsigned ALU_WIDTH   = 16;
   localparam int unsigned ALU_SHAMT_W = 4;

   typedef enum logic [2:0] {
      ALU_ADD = 3'd0,
      ALU_XOR = 3'd1,
      ALU_AND = 3'd2,
      ALU_OR  = 3'd3,
      ALU_ROL = 3'd4,
      ALU_SLL = 3'd5,
      ALU_ROR = 3'd6,
      ALU_SRL = 3'd7
   } aluOp_e;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } aluState_e;

   // Shift/rotate encodings all have the MSB of the op code set.
   function automatic logic isShift(input aluOp_e opCode);
      return opCode[2];
   endfunction

endpackage

// File: rtl/alu_shift_step.sv
// -----------------------------------------------------------------------------
// alu_shift_step
//   Combinational one-bit shift/rotate of a WIDTH-bit word.
//   Ports:
//     op      in   shift/rotate selector (non-shift codes pass data through)
//     dataIn  in   word to shift
//     dataOut out  word moved by one bit position
// -----------------------------------------------------------------------------
module alu_shift_step
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH = ALU_WIDTH
) (
   input  aluOp_e           op,
   input  logic [WIDTH-1:0] dataIn,
   output logic [WIDTH-1:0] dataOut
);

   always_comb begin
      dataOut = dataIn;
      case (op)
         ALU_ROL: dataOut = {dataIn[WIDTH-2:0], dataIn[WIDTH-1]};
         ALU_SLL: dataOut = {dataIn[WIDTH-2:0], 1'b0};
         ALU_ROR: dataOut = {dataIn[0], dataIn[WIDTH-1:1]};
         ALU_SRL: dataOut = {1'b0, dataIn[WIDTH-1:1]};
         default: dataOut = dataIn;
      endcase
   end

endmodule

// File: rtl/alu_exec_unit.sv
// -----------------------------------------------------------------------------
// alu_exec_unit
//   Multi-cycle EX-stage execute unit: operand inversion, add/logic in one
//   cycle, shifts/rotates one bit per cycle (or single-cycle when the barrel
//   shifter is compiled in via `ALU_BARREL_SHIFT_EN`).
//   Ports:
//     clk, rst_n        clock (rising edge), async active-low reset
//     start             request, sampled only when not busy
//     op[2:0]           operation (see alu_pkg::aluOp_e)
//     A, B              operands; B[SHAMT_W-1:0] is the shift amount
//     invA, invB, Cin   operand inversion and ADD carry-in
//     busy              shift in progress
//     done              one-cycle completion pulse
//     result            registered result
//     Ofl, Zero         signed-overflow (ADD only) and result==0 flags
// -----------------------------------------------------------------------------
module alu_exec_unit
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH   = ALU_WIDTH,
   parameter int unsigned SHAMT_W = ALU_SHAMT_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             invA,
   input  logic             invB,
   input  logic             Cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             Ofl,
   output logic             Zero
);

   aluState_e          state;
   aluOp_e             opIn;
   logic [WIDTH-1:0]   ain;
   logic [WIDTH-1:0]   bin;
   logic [WIDTH-1:0]   sum;
   logic [WIDTH-1:0]   shiftImm;
   logic [WIDTH-1:0]   imm;
   logic               immOfl;
   logic [SHAMT_W-1:0] k;

   assign opIn = aluOp_e'(op);
   assign ain  = invA ? ~A : A;
   assign bin  = invB ? ~B : B;
   assign k    = B[SHAMT_W-1:0];
   assign sum  = ain + bin + WIDTH'(Cin);

`ifdef ALU_BARREL_SHIFT_EN
   // Stage s conditionally moves the word by 2**s bits under control of k[s].
   logic [SHAMT_W:0][WIDTH-1:0] stage;
   assign stage[0] = ain;
   for (genvar s = 0; s < SHAMT_W; s++) begin : gBarrel
      localparam int unsigned D = 1 << s;
      logic [WIDTH-1:0] moved;
      always_comb begin
         case (opIn)
            ALU_ROL: moved = {stage[s][WIDTH-1-D:0], stage[s][WIDTH-1 -: D]};
            ALU_SLL: moved = {stage[s][WIDTH-1-D:0], {D{1'b0}}};
            ALU_ROR: moved = {stage[s][D-1:0], stage[s][WIDTH-1:D]};
            default: moved = {{D{1'b0}}, stage[s][WIDTH-1:D]};
         endcase
      end
      assign stage[s+1] = k[s] ? moved : stage[s];
   end
   assign shiftImm = stage[SHAMT_W];
   assign busy     = 1'b0;
`else
   logic [WIDTH-1:0]   workReg;
   logic [WIDTH-1:0]   stepOut;
   logic [SHAMT_W-1:0] cnt;
   aluOp_e             opReg;
   logic               busyQ;
   logic               takeShift;

   alu_shift_step #(.WIDTH(WIDTH)) uStep (
      .op      (opReg),
      .dataIn  (workReg),
      .dataOut (stepOut)
   );

   // Only reached for k==0, where the shift is the identity.
   assign shiftImm  = ain;
   assign takeShift = isShift(opIn) && (k != '0);
   assign busy      = busyQ;
`endif

   always_comb begin
      imm    = shiftImm;
      immOfl = 1'b0;
      case (opIn)
         ALU_ADD: begin
            imm    = sum;
            immOfl = (ain[WIDTH-1] == bin[WIDTH-1]) && (sum[WIDTH-1] != ain[WIDTH-1]);
         end
         ALU_XOR: imm = ain ^ bin;
         ALU_AND: imm = ain & bin;
         ALU_OR:  imm = ain | bin;
         default: imm = shiftImm;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= ST_IDLE;
         result <= '0;
         Ofl    <= 1'b0;
         Zero   <= 1'b0;
         done   <= 1'b0;
`ifndef ALU_BARREL_SHIFT_EN
         busyQ   <= 1'b0;
         workReg <= '0;
         cnt     <= '0;
         opReg   <= ALU_ADD;
`endif
      end else begin
         done <= 1'b0;
         case (state)
            // DONE accepts a new request exactly like IDLE so ops can issue back to back.
            ST_IDLE, ST_DONE: begin
               state <= ST_IDLE;
               if (start) begin
`ifndef ALU_BARREL_SHIFT_EN
                  if (takeShift) begin
                     state   <= ST_SHIFT;
                     workReg <= ain;
                     opReg   <= opIn;
                     cnt     <= k;
                     busyQ   <= 1'b1;
                  end else
`endif
                  begin
                     state  <= ST_DONE;
                     result <= imm;
                     Ofl    <= immOfl;
                     Zero   <= (imm == '0);
                     done   <= 1'b1;
                  end
               end
            end
`ifndef ALU_BARREL_SHIFT_EN
            ST_SHIFT: begin
               workReg <= stepOut;
               cnt     <= cnt - SHAMT_W'(1);
               if (cnt == SHAMT_W'(1)) begin
                  state  <= ST_DONE;
                  result <= stepOut;
                  Ofl    <= 1'b0;
                  Zero   <= (stepOut == '0);
                  done   <= 1'b1;
                  busyQ  <= 1'b0;
               end
            end
`endif
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_exec_unit.sv
`timescale 1ns/1ps
module tb_alu_exec_unit;

   localparam int unsigned W = 16;

`ifdef ALU_BARREL_SHIFT_EN
   localparam bit BARREL = 1'b1;
`else
   localparam bit BARREL = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst_n;
   logic          start;
   logic [2:0]    op;
   logic [W-1:0]  A;
   logic [W-1:0]  B;
   logic          invA;
   logic          invB;
   logic          Cin;
   logic          busy;
   logic          done;
   logic [W-1:0]  result;
   logic          Ofl;
   logic          Zero;

   alu_exec_unit #(.WIDTH(16), .SHAMT_W(4)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (start),
      .op     (op),
      .A      (A),
      .B      (B),
      .invA   (invA),
      .invB   (invB),
      .Cin    (Cin),
      .busy   (busy),
      .done   (done),
      .result (result),
      .Ofl    (Ofl),
      .Zero   (Zero)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] res;
      logic        ofl;
      logic        zero;
      int unsigned doneEdge;
   } exp_t;

   exp_t        sb[$];
   int unsigned edgeCnt  = 0;
   int unsigned busyFrom = 1;
   int unsigned busyTo   = 0;
   int          compared   = 0;
   int          mismatched = 0;

   always @(posedge clk) edgeCnt <= edgeCnt + 1;

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
      compared++;
      if (act !== req) begin
         mismatched++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
      end
   endfunction

   // Reference model: plain integer arithmetic on the operation's definition.
   function automatic void model(input logic [2:0] o, input logic [15:0] a, input logic [15:0] b,
                                 input logic ia, input logic ib, input logic ci,
                                 output logic [15:0] r, output logic ov);
      logic [15:0] ain;
      logic [15:0] bin;
      logic [31:0] x;
      int unsigned kk;
      int          s;
      ain = ia ? ~a : a;
      bin = ib ? ~b : b;
      kk  = int'(b[3:0]);
      x   = {16'h0000, ain};
      ov  = 1'b0;
      r   = 16'h0000;
      case (o)
         3'd0: begin
            r  = 16'(int'(ain) + int'(bin) + int'(ci));
            s  = int'($signed(ain)) + int'($signed(bin)) + int'(ci);
            ov = (s > 32767) || (s < -32768);
         end
         3'd1: r = ain ^ bin;
         3'd2: r = ain & bin;
         3'd3: r = ain | bin;
         3'd4: r = 16'((x << kk) | (x >> (16 - kk)));
         3'd5: r = 16'(x << kk);
         3'd6: r = 16'((x >> kk) | (x << (16 - kk)));
         default: r = 16'(x >> kk);
      endcase
   endfunction

   // Issue one request; caller is positioned just after a rising edge.
   task automatic issue(input logic [2:0] o, input logic [15:0] a, input logic [15:0] b,
                        input logic ia, input logic ib, input logic ci);
      int unsigned w;
      int unsigned acc;
      int unsigned lat;
      int unsigned kk;
      exp_t        e;
      w = 0;
      while (busy && w < 40) begin
         @(posedge clk); #1;
         w++;
      end
      if (busy) begin
         chk("issue_wait_busy", 32'(busy), 32'd0);
         return;
      end
      op = o; A = a; B = b; invA = ia; invB = ib; Cin = ci;
      start = 1'b1;
      acc = edgeCnt + 1;
      kk  = int'(b[3:0]);
      lat = (!BARREL && o[2] && kk != 0) ? kk + 1 : 1;
      model(o, a, b, ia, ib, ci, e.res, e.ofl);
      e.zero     = (e.res == 16'h0000);
      e.doneEdge = acc + lat - 1;
      sb.push_back(e);
      if (lat > 1) begin
         busyFrom = acc;
         busyTo   = acc + kk - 1;
      end
      @(posedge clk); #1;
      start = 1'b0;
      // Inputs are not sampled mid-shift; scramble them to prove it.
      A = 16'($urandom); B = 16'($urandom);
      invA = 1'($urandom); invB = 1'($urandom); Cin = 1'($urandom);
   endtask

   // Monitor: pops the scoreboard whenever the DUT signals completion.
   always @(negedge clk) begin
      if (rst_n) begin
         chk("busy", 32'(busy), 32'(edgeCnt >= busyFrom && edgeCnt <= busyTo));
         if (busy && done) chk("busy_and_done", 32'(busy && done), 32'd0);
         if (done) begin
            if (sb.size() == 0) begin
               chk("unexpected_done", 32'(done), 32'd0);
            end else begin
               exp_t e;
               e = sb.pop_front();
               chk("result", 32'(result), 32'(e.res));
               chk("Ofl", 32'(Ofl), 32'(e.ofl));
               chk("Zero", 32'(Zero), 32'(e.zero));
               chk("done_edge", edgeCnt, e.doneEdge);
            end
         end else if (sb.size() > 0 && edgeCnt > sb[0].doneEdge) begin
            chk("missing_done", 32'(done), 32'd1);
            void'(sb.pop_front());
         end
      end
   end

   initial begin
      rst_n = 1'b0; start = 1'b0; op = 3'd0; A = '0; B = '0;
      invA = 1'b0; invB = 1'b0; Cin = 1'b0;
      #2;
      chk("rst_result", 32'(result), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_Ofl", 32'(Ofl), 32'd0);
      chk("rst_Zero", 32'(Zero), 32'd0);
      @(posedge clk); @(posedge clk); #1;
      rst_n = 1'b1;

      issue(3'd0, 16'h0005, 16'h0003, 1'b1, 1'b0, 1'b1);   // B-A = 0xFFFE
      issue(3'd0, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b0);   // 0x8000, Ofl
      issue(3'd0, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0);   // 0x0000, Zero
      issue(3'd6, 16'h0001, 16'h0004, 1'b0, 1'b0, 1'b0);   // ROR 4 -> 0x1000
      issue(3'd7, 16'h8000, 16'h000F, 1'b0, 1'b0, 1'b0);   // SRL 15 -> 0x0001
      issue(3'd5, 16'h1234, 16'h0000, 1'b0, 1'b0, 1'b0);   // SLL 0 -> 0x1234
      issue(3'd4, 16'h00FF, 16'h0008, 1'b0, 1'b0, 1'b0);   // ROL 8 -> 0xFF00
      if (!BARREL) begin
         // Stray start mid-shift must be dropped.
         op = 3'd1; A = 16'hAAAA; B = 16'h5555; start = 1'b1;
         @(posedge clk); #1;
         start = 1'b0;
      end

      // Abort a k=10 shift with reset during its third cycle.
      issue(3'd5, 16'h0F0F, 16'h000A, 1'b0, 1'b0, 1'b0);
      @(posedge clk); #2;
      rst_n = 1'b0;
      sb.delete();
      busyTo = 0;
      #1;
      chk("abort_result", 32'(result), 32'd0);
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_done", 32'(done), 32'd0);
      chk("abort_Zero", 32'(Zero), 32'd0);
      @(posedge clk); @(posedge clk); #1;
      rst_n = 1'b1;
      issue(3'd1, 16'hFF00, 16'h0FF0, 1'b0, 1'b0, 1'b0);   // 0xF0F0

      for (int i = 0; i < 80; i++) begin
         if ($urandom_range(3) == 0) begin
            @(posedge clk); #1;
         end
         issue(3'($urandom_range(7)), 16'($urandom), 16'($urandom),
               1'($urandom_range(1)), 1'($urandom_range(1)), 1'($urandom_range(1)));
      end

      for (int i = 0; i < 60 && sb.size() > 0; i++) begin
         @(posedge clk); #1;
      end
      if (sb.size() > 0) chk("drain", 32'(sb.size()), 32'd0);
      @(posedge clk); #1;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
